// File: rtl/ldst_unit.sv
// Load/store unit: one outstanding access between the execute stage and a word-addressed bus,
// with alignment checking, byte-lane steering, load sign/zero extension and a response timeout.
module ldst_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ldst_req_vld,
  output logic        ldst_req_rdy,
  input  logic        ldst_req_st,
  input  logic [1:0]  ldst_req_size,
  input  logic        ldst_req_uns,
  input  logic [31:0] ldst_req_addr,
  input  logic [31:0] ldst_req_wdata,
  output logic        ldst_rsp_vld,
  input  logic        ldst_rsp_rdy,
  output logic [31:0] ldst_rsp_rdata,
  output logic        ldst_rsp_err,
  output logic        bus_req_vld,
  input  logic        bus_req_rdy,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_be,
  input  logic        bus_rsp_vld,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err
);

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StRsp} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        st_q, uns_q;
  logic [1:0]  size_q, off_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic        accept, misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign accept = ldst_req_vld && (state_q == StIdle);

  always_comb begin
    case (ldst_req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = ldst_req_addr[0];
      2'd2:    misaligned = |ldst_req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Sub-word stores replicate the data so the bus sees it on whichever lane is enabled.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = ldst_req_wdata;
    if (ldst_req_st) begin
      case (ldst_req_size)
        2'd0: begin
          be_new    = 4'b0001 << ldst_req_addr[1:0];
          wdata_new = {4{ldst_req_wdata[7:0]}};
        end
        2'd1: begin
          be_new    = 4'b0011 << ldst_req_addr[1:0];
          wdata_new = {2{ldst_req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lane_b = bus_rsp_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? bus_rsp_rdata[31:16] : bus_rsp_rdata[15:0];
    case (size_q)
      2'd0:    load_data = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'd1:    load_data = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_data = bus_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          rdata_d = '0;
          err_d   = misaligned;
          state_d = misaligned ? StRsp : StReq;
        end
      end
      StReq: begin
        if (bus_req_rdy) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_rsp_vld) begin
          err_d   = bus_rsp_err;
          rdata_d = (bus_rsp_err || st_q) ? '0 : load_data;
          state_d = StRsp;
        end else if (cnt_q + 16'd1 == TimeoutCnt) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (ldst_rsp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ldst_req_rdy = (state_q == StIdle);
    bus_req_vld  = (state_q == StReq);
    ldst_rsp_vld = (state_q == StRsp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      st_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        st_q    <= ldst_req_st;
        uns_q   <= ldst_req_uns;
        size_q  <= ldst_req_size;
        off_q   <= ldst_req_addr[1:0];
        we_q    <= ldst_req_st;
        addr_q  <= {ldst_req_addr[31:2], 2'b00};
        wdata_q <= wdata_new;
        be_q    <= be_new;
      end
    end
  end

  assign ldst_rsp_rdata = rdata_q;
  assign ldst_rsp_err   = err_q;
  assign bus_req_we     = we_q;
  assign bus_req_addr   = addr_q;
  assign bus_req_wdata  = wdata_q;
  assign bus_req_be     = be_q;

endmodule

// File: tb/tb_ldst_unit.sv
// Bench for ldst_unit: directed scenarios plus randomized transactions checked against an
// arithmetic model of lane selection, extension, alignment and timeout timing.
module tb_ldst_unit;
  localparam int To = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ldst_req_vld, ldst_req_rdy, ldst_req_st, ldst_req_uns;
  logic [1:0]  ldst_req_size;
  logic [31:0] ldst_req_addr, ldst_req_wdata;
  logic        ldst_rsp_vld, ldst_rsp_rdy, ldst_rsp_err;
  logic [31:0] ldst_rsp_rdata;
  logic        bus_req_vld, bus_req_rdy, bus_req_we;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_be;
  logic        bus_rsp_vld, bus_rsp_err;
  logic [31:0] bus_rsp_rdata;

  int checks = 0;
  int errors = 0;

  // Observations recorded by the transaction driver.
  bit          o_done, o_bus_seen, o_bus_unstable, o_rsp_unstable, o_rdy_bad, o_rdy_after;
  bit          o_vld_after;
  logic [31:0] o_bus_addr, o_bus_wdata, o_rdata;
  logic [3:0]  o_bus_be;
  logic        o_bus_we, o_err;
  int          t_acc, t_bvld, t_bus, t_rsp;

  ldst_unit #(.TIMEOUT(To)) dut (
    .clk(clk), .rst(rst),
    .ldst_req_vld(ldst_req_vld), .ldst_req_rdy(ldst_req_rdy), .ldst_req_st(ldst_req_st),
    .ldst_req_size(ldst_req_size), .ldst_req_uns(ldst_req_uns), .ldst_req_addr(ldst_req_addr),
    .ldst_req_wdata(ldst_req_wdata), .ldst_rsp_vld(ldst_rsp_vld), .ldst_rsp_rdy(ldst_rsp_rdy),
    .ldst_rsp_rdata(ldst_rsp_rdata), .ldst_rsp_err(ldst_rsp_err), .bus_req_vld(bus_req_vld),
    .bus_req_rdy(bus_req_rdy), .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_be(bus_req_be), .bus_rsp_vld(bus_rsp_vld),
    .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit model_mis(input int sz, input logic [31:0] addr);
    if (sz == 3) return 1'b1;
    return (addr % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic st, input int sz, input int off);
    logic [3:0] be;
    int nb;
    if (!st) return 4'hF;
    nb = 1 << sz;
    be = '0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] w, input logic st, input int sz);
    logic [31:0] r;
    int nb;
    if (!st) return w;
    nb = 1 << sz;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int sz,
                                             input logic uns, input int off);
    longint unsigned v, lim;
    int nb;
    nb = 1 << sz;
    if (nb == 4) return word;
    lim = 64'd1 << (8 * nb);
    v = (longint'(word) >> (8 * off)) % lim;
    if (!uns && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  // ---------------- transaction driver (records, does not judge) ----------------
  task automatic run_txn(input logic st, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int req_rdy_dly, input int rsp_dly, input logic [31:0] brdata,
                         input logic berr, input int rsp_rdy_dly);
    int n;
    bit acc, bacc;
    o_done = 0; o_bus_seen = 0; o_bus_unstable = 0; o_rsp_unstable = 0; o_rdy_bad = 0;
    t_acc = -1; t_bvld = -1; t_bus = -1; t_rsp = -1;
    acc = 0; bacc = 0; n = 0;
    @(negedge clk);
    ldst_req_st = st; ldst_req_size = size; ldst_req_uns = uns;
    ldst_req_addr = addr; ldst_req_wdata = wdata;
    while (!o_done && n < 100) begin
      if (acc && ldst_req_rdy) o_rdy_bad = 1;
      if (bus_req_vld) begin
        if (!o_bus_seen) begin
          o_bus_seen = 1; t_bvld = n;
          o_bus_addr = bus_req_addr; o_bus_wdata = bus_req_wdata;
          o_bus_be = bus_req_be; o_bus_we = bus_req_we;
        end else if ({bus_req_addr, bus_req_wdata, bus_req_be, bus_req_we} !==
                     {o_bus_addr, o_bus_wdata, o_bus_be, o_bus_we}) begin
          o_bus_unstable = 1;
        end
      end
      if (ldst_rsp_vld) begin
        if (t_rsp < 0) begin
          t_rsp = n; o_rdata = ldst_rsp_rdata; o_err = ldst_rsp_err;
        end else if ({ldst_rsp_rdata, ldst_rsp_err} !== {o_rdata, o_err}) begin
          o_rsp_unstable = 1;
        end
      end
      ldst_req_vld = !acc;
      if (!acc && ldst_req_rdy) begin acc = 1; t_acc = n; end
      bus_req_rdy = bus_req_vld && !bacc && (n - t_bvld >= req_rdy_dly);
      if (bus_req_rdy) begin bacc = 1; t_bus = n; end
      bus_rsp_vld = bacc && rsp_dly >= 0 && (n == t_bus + rsp_dly);
      bus_rsp_rdata = bus_rsp_vld ? brdata : $urandom;
      bus_rsp_err = bus_rsp_vld ? berr : 1'($urandom);
      ldst_rsp_rdy = (t_rsp >= 0) && (n - t_rsp >= rsp_rdy_dly);
      if (ldst_rsp_rdy && ldst_rsp_vld) o_done = 1;
      @(negedge clk);
      n++;
    end
    o_rdy_after = ldst_req_rdy;
    o_vld_after = ldst_rsp_vld;
    ldst_req_vld = 0; bus_req_rdy = 0; bus_rsp_vld = 0; ldst_rsp_rdy = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    ldst_req_vld = 0; ldst_req_st = 0; ldst_req_size = 0; ldst_req_uns = 0;
    ldst_req_addr = 0; ldst_req_wdata = 0; ldst_rsp_rdy = 0; bus_req_rdy = 0;
    bus_rsp_vld = 0; bus_rsp_rdata = 0; bus_rsp_err = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if (ldst_req_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_rdy: got %b want 1", ldst_req_rdy);
    end
    checks++;
    if ({ldst_rsp_vld, bus_req_vld} !== 2'b00) begin
      errors++; $display("FAIL reset_vld: rsp_vld=%b bus_vld=%b want 0 0", ldst_rsp_vld, bus_req_vld);
    end
    checks++;
    if ({ldst_rsp_rdata, ldst_rsp_err} !== 33'd0) begin
      errors++; $display("FAIL reset_rsp: rdata=%h err=%b want 0 0", ldst_rsp_rdata, ldst_rsp_err);
    end
    checks++;
    if ({bus_req_be, bus_req_we, bus_req_addr, bus_req_wdata} !== 69'd0) begin
      errors++;
      $display("FAIL reset_bus: be=%b we=%b addr=%h wdata=%h want all 0",
               bus_req_be, bus_req_we, bus_req_addr, bus_req_wdata);
    end
  endtask

  task automatic test_lb();
    run_txn(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 0, 1, 32'h80FF_FF00, 1'b0, 0);
    checks++;
    if ({o_bus_addr, o_bus_be, o_bus_we} !== {32'h0000_1000, 4'b1111, 1'b0}) begin
      errors++; $display("FAIL lb_bus: addr=%h be=%b we=%b want 00001000 1111 0",
                         o_bus_addr, o_bus_be, o_bus_we);
    end
    checks++;
    if ({o_rdata, o_err} !== {32'hFFFF_FF80, 1'b0}) begin
      errors++; $display("FAIL lb_rsp: rdata=%h err=%b want ffffff80 0", o_rdata, o_err);
    end
    checks++;
    if (!o_done || t_rsp - t_acc != 3) begin
      errors++; $display("FAIL lb_latency: done=%0d lat=%0d want 1 3", o_done, t_rsp - t_acc);
    end
  endtask

  task automatic test_sh();
    run_txn(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 0, 1, 32'hDEAD_BEEF, 1'b0, 0);
    checks++;
    if ({o_bus_be, o_bus_wdata, o_bus_we, o_bus_addr} !==
        {4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0000_2000}) begin
      errors++; $display("FAIL sh_bus: be=%b wdata=%h we=%b addr=%h want 1100 abcdabcd 1 00002000",
                         o_bus_be, o_bus_wdata, o_bus_we, o_bus_addr);
    end
    checks++;
    if ({o_rdata, o_err} !== 33'd0 || !o_done) begin
      errors++; $display("FAIL sh_rsp: rdata=%h err=%b done=%0d want 0 0 1", o_rdata, o_err, o_done);
    end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 0, 1, 32'h1111_1111, 1'b0, 0);
    checks++;
    if (o_bus_seen || !o_done || {o_rdata, o_err} !== {32'h0, 1'b1} || t_rsp - t_acc != 1) begin
      errors++; $display("FAIL lw_misaligned: bus=%0d rdata=%h err=%b lat=%0d want 0 0 1 1",
                         o_bus_seen, o_rdata, o_err, t_rsp - t_acc);
    end
    run_txn(1'b1, 2'd3, 1'b0, 32'h0000_3000, 32'h5555_5555, 0, 1, 32'h0, 1'b0, 1);
    checks++;
    if (o_bus_seen || !o_done || {o_rdata, o_err} !== {32'h0, 1'b1} || t_rsp - t_acc != 1) begin
      errors++; $display("FAIL size3: bus=%0d rdata=%h err=%b lat=%0d want 0 0 1 1",
                         o_bus_seen, o_rdata, o_err, t_rsp - t_acc);
    end
  endtask

  task automatic test_timeout();
    bit leak;
    // Bus pulses one cycle after the timeout fires: must be ignored while in RSP.
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 0, To + 1, 32'h7777_7777, 1'b0, 2);
    checks++;
    if (!o_done || {o_rdata, o_err} !== {32'h0, 1'b1} || o_rsp_unstable) begin
      errors++; $display("FAIL timeout_rsp: rdata=%h err=%b unstable=%0d want 0 1 0",
                         o_rdata, o_err, o_rsp_unstable);
    end
    checks++;
    if (t_rsp - t_bus != To + 1) begin
      errors++; $display("FAIL timeout_time: rsp %0d cycles after bus accept, want %0d",
                         t_rsp - t_bus - 1, To);
    end
    leak = 0;
    bus_rsp_vld = 1; bus_rsp_rdata = 32'h1234_5678; bus_rsp_err = 0;
    @(negedge clk);
    bus_rsp_vld = 0;
    repeat (3) begin
      if (ldst_rsp_vld || !ldst_req_rdy) leak = 1;
      @(negedge clk);
    end
    checks++;
    if (leak) begin
      errors++; $display("FAIL late_rsp_idle: stray response leaked=%0d want 0", leak);
    end
    run_txn(1'b0, 2'd0, 1'b0, 32'h0000_7001, 32'h0, 0, 1, 32'h0000_7F00, 1'b0, 0);
    checks++;
    if (!o_done || {o_rdata, o_err} !== {32'h0000_007F, 1'b0}) begin
      errors++; $display("FAIL after_timeout: rdata=%h err=%b want 0000007f 0", o_rdata, o_err);
    end
  endtask

  task automatic test_lhu_stall();
    run_txn(1'b0, 2'd1, 1'b1, 32'h0000_4002, 32'h0, 3, 1, 32'h8001_0000, 1'b0, 2);
    checks++;
    if (o_bus_unstable || t_bus - t_bvld != 3) begin
      errors++; $display("FAIL lhu_bus_stable: unstable=%0d wait=%0d want 0 3",
                         o_bus_unstable, t_bus - t_bvld);
    end
    checks++;
    if (!o_done || {o_rdata, o_err} !== {32'h0000_8001, 1'b0} || o_rsp_unstable) begin
      errors++; $display("FAIL lhu_rsp: rdata=%h err=%b unstable=%0d want 00008001 0 0",
                         o_rdata, o_err, o_rsp_unstable);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b1, 0);
    checks++;
    if ({o_rdata, o_err} !== {32'h0, 1'b1}) begin
      errors++; $display("FAIL bus_err: rdata=%h err=%b want 0 1", o_rdata, o_err);
    end
    checks++;
    if (o_rdy_bad || !o_rdy_after || o_vld_after) begin
      errors++; $display("FAIL rdy_timing: busy_rdy=%0d rdy_after=%0d vld_after=%0d want 0 1 0",
                         o_rdy_bad, o_rdy_after, o_vld_after);
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    @(negedge clk);
    ldst_req_vld = 1; ldst_req_st = 0; ldst_req_size = 2'd2; ldst_req_addr = 32'h0000_6000;
    @(negedge clk);
    ldst_req_vld = 0; bus_req_rdy = 1;
    @(negedge clk);
    bus_req_rdy = 0;
    checks++;
    if (bus_req_vld || ldst_req_rdy || ldst_rsp_vld) begin
      errors++; $display("FAIL mid_wait: bus_vld=%b rdy=%b rsp_vld=%b want 0 0 0",
                         bus_req_vld, ldst_req_rdy, ldst_rsp_vld);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    bus_rsp_vld = 1; bus_rsp_rdata = 32'hFFFF_FFFF; bus_rsp_err = 0;
    @(negedge clk);
    bus_rsp_vld = 0;
    bad = 0;
    repeat (4) begin
      if (ldst_rsp_vld || !ldst_req_rdy || bus_req_vld || bus_req_be !== 4'b0) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reset_mid: activity after abandoned txn=%0d want 0", bad);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic        st, uns, berr;
      logic [1:0]  size;
      logic [31:0] addr, wdata, brdata, exp_rdata;
      int          rsp_dly, sz, off;
      bit          mis, hit, exp_err;
      st = 1'($urandom); uns = 1'($urandom); berr = ($urandom_range(0, 7) == 0);
      size = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom; brdata = $urandom;
      if ($urandom_range(0, 3) != 0 && size != 2'd3) addr[1:0] = addr[1:0] & ~2'(size * 1 + size / 2);
      rsp_dly = $urandom_range(0, To + 2);
      run_txn(st, size, uns, addr, wdata, $urandom_range(0, 2), rsp_dly, brdata, berr,
              $urandom_range(0, 2));
      sz = int'(size); off = int'(addr[1:0]);
      mis = model_mis(sz, addr);
      hit = !mis && rsp_dly >= 1 && rsp_dly <= To;
      exp_err = mis || !hit || berr;
      exp_rdata = (exp_err || st) ? 32'h0 : model_load(brdata, sz, uns, off);
      checks++;
      if (o_bus_seen !== !mis || (!mis && {o_bus_addr, o_bus_be, o_bus_we, o_bus_wdata} !==
          {addr & 32'hFFFF_FFFC, model_be(st, sz, off), st, model_wdata(wdata, st, sz)})) begin
        errors++;
        $display("FAIL rnd%0d_bus: seen=%0d addr=%h be=%b we=%b wdata=%h want seen=%0d %h %b %b %h",
                 k, o_bus_seen, o_bus_addr, o_bus_be, o_bus_we, o_bus_wdata, !mis,
                 addr & 32'hFFFF_FFFC, model_be(st, sz, off), st, model_wdata(wdata, st, sz));
      end
      checks++;
      if (!o_done || {o_rdata, o_err} !== {exp_rdata, exp_err}) begin
        errors++; $display("FAIL rnd%0d_rsp: done=%0d rdata=%h err=%b want %h %b",
                           k, o_done, o_rdata, o_err, exp_rdata, exp_err);
      end
      checks++;
      if (!mis && t_rsp - t_bus != (hit ? rsp_dly + 1 : To + 1)) begin
        errors++; $display("FAIL rnd%0d_time: rsp at bus+%0d want bus+%0d",
                           k, t_rsp - t_bus, hit ? rsp_dly + 1 : To + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_timeout();
    test_lhu_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
